// File: rtl/axi_burst_master_if.sv
// ---------------------------------------------------------------------------
// axi_burst_master_if
//
// Purpose: the five AXI3 channels (AW, W, B, AR, R) used between the burst
// master and an AXI slave, bundled so both sides connect through one port.
//
// Parameters:
//   ID_W  width of awid/wid/bid/arid/rid
//   DW    data width; wstrb is DW/8 bits
//
// Modports:
//   master  drives AW/W/AR payloads and valids, bready and rready
//   slave   drives awready/wready/arready and the B and R channels
// ---------------------------------------------------------------------------
interface axi_burst_master_if #(
    parameter int ID_W = 4,
    parameter int DW   = 32
);
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] awid;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [31:0]     awaddr;
    logic [1:0]      awburst;

    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] wid;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] arid;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [31:0]     araddr;
    logic [1:0]      arburst;

    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] rid;
    logic [DW-1:0]   rdata;
    logic            rlast;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awid, awlen, awsize, awaddr, awburst,
        input  awready,
        output wvalid, wid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, arlen, arsize, araddr, arburst,
        input  arready,
        input  rvalid, rid, rdata, rlast, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awid, awlen, awsize, awaddr, awburst,
        output awready,
        input  wvalid, wid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, arlen, arsize, araddr, arburst,
        output arready,
        output rvalid, rid, rdata, rlast, rresp,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// ---------------------------------------------------------------------------
// axi_burst_master
//
// Purpose: turns one local command into a single INCR write or read burst on
// AXI3 and reports completion status. One transaction in flight at a time.
//
// Handshakes: every channel here (cmd, wr, rd, AXI) transfers a beat on a
// rising clk edge where valid and ready are both 1. A valid never depends on
// the ready of the same channel.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_write/addr/len/id        command fields (len = beats - 1)
//   wr_valid/wr_ready/data/strb  local write-data source
//   rd_valid/rd_ready/data/last  local read-data sink
//   done_valid                   one-cycle completion pulse
//   done_write/id/resp/err       status of the completed command
//   dbg_state                    current FSM state (0 = IDLE)
//   axi                          AXI master modport (AW, W, B, AR, R)
// ---------------------------------------------------------------------------
module axi_burst_master #(
    parameter int AXI_ID_W = 4,
    parameter int AXI_DW   = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [31:0]         cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [AXI_ID_W-1:0] cmd_id,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AXI_DW-1:0]   wr_data,
    input  logic [AXI_DW/8-1:0] wr_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [AXI_DW-1:0]   rd_data,
    output logic                rd_last,
    output logic                done_valid,
    output logic                done_write,
    output logic [AXI_ID_W-1:0] done_id,
    output logic [1:0]          done_resp,
    output logic                done_err,
    output logic [2:0]          dbg_state,
    axi_burst_master_if.master  axi
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WDATA = 3'd2,
        S_WRESP = 3'd3,
        S_RADDR = 3'd4,
        S_RDATA = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [3:0]            beat_q, beat_d;
    logic [1:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  done_valid_q, done_valid_d;
    logic                  done_write_q, done_write_d;
    logic [AXI_ID_W-1:0]   done_id_q, done_id_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic                  done_err_q, done_err_d;

    logic in_wdata, in_rdata, wlast, w_hs, r_hs, beat_err;
    logic [1:0] resp_max;

    // Data-phase signals are gated by state flops, so an asynchronous reset
    // drops them in the same instant it clears the state.
    assign in_wdata = (state_q == S_WDATA);
    assign in_rdata = (state_q == S_RDATA);
    assign wlast    = (beat_q == len_q);
    assign w_hs     = wr_valid & in_wdata & axi.wready;
    assign r_hs     = axi.rvalid & rd_ready & in_rdata;

    assign cmd_ready   = cmd_ready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awid    = id_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = 3'b010;
    assign axi.awaddr  = addr_q;
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = wr_valid & in_wdata;
    assign axi.wid     = id_q;
    assign axi.wdata   = wr_data;
    assign axi.wstrb   = wr_strb;
    assign axi.wlast   = wlast;
    assign axi.bready  = (state_q == S_WRESP);
    assign axi.arvalid = arvalid_q;
    assign axi.arid    = id_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = 3'b010;
    assign axi.araddr  = addr_q;
    assign axi.arburst = 2'b01;
    assign axi.rready  = rd_ready & in_rdata;
    assign wr_ready    = axi.wready & in_wdata;
    assign rd_valid    = axi.rvalid & in_rdata;
    assign rd_data     = axi.rdata;
    assign rd_last     = axi.rlast;
    assign done_valid  = done_valid_q;
    assign done_write  = done_write_q;
    assign done_id     = done_id_q;
    assign done_resp   = done_resp_q;
    assign done_err    = done_err_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        beat_d       = beat_q;
        resp_d       = resp_q;
        err_d        = err_q;
        awvalid_d    = awvalid_q;
        arvalid_d    = arvalid_q;
        done_valid_d = 1'b0;
        done_write_d = done_write_q;
        done_id_d    = done_id_q;
        done_resp_d  = done_resp_q;
        done_err_d   = done_err_q;
        resp_max     = (axi.rresp > resp_q) ? axi.rresp : resp_q;
        // Wrong ID, rlast before the last beat, or no rlast on the last beat.
        beat_err     = (axi.rid != id_q) || (axi.rlast && !wlast) || (!axi.rlast && wlast);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    id_d   = cmd_id;
                    beat_d = 4'd0;
                    resp_d = 2'b00;
                    err_d  = 1'b0;
                    if (cmd_write) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WADDR: begin
                if (axi.awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 4'd1;
                    if (wlast) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (axi.bvalid) begin
                    state_d      = S_IDLE;
                    done_valid_d = 1'b1;
                    done_write_d = 1'b1;
                    done_id_d    = id_q;
                    done_resp_d  = axi.bresp;
                    done_err_d   = (axi.bid != id_q);
                end
            end
            S_RADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    beat_d = beat_q + 4'd1;
                    resp_d = resp_max;
                    err_d  = err_q | beat_err;
                    // rlast ends the burst even when it arrives early.
                    if (axi.rlast) begin
                        state_d      = S_IDLE;
                        done_valid_d = 1'b1;
                        done_write_d = 1'b0;
                        done_id_d    = id_q;
                        done_resp_d  = resp_max;
                        done_err_d   = err_q | beat_err;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready: high in every IDLE cycle, including the one
        // carrying the done pulse, so back-to-back commands are possible.
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            beat_q       <= '0;
            resp_q       <= '0;
            err_q        <= 1'b0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_write_q <= 1'b0;
            done_id_q    <= '0;
            done_resp_q  <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            beat_q       <= beat_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            cmd_ready_q  <= cmd_ready_d;
            done_valid_q <= done_valid_d;
            done_write_q <= done_write_d;
            done_id_q    <= done_id_d;
            done_resp_q  <= done_resp_d;
            done_err_q   <= done_err_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_master
//
// Purpose: self-checking bench for axi_burst_master. A table of directed
// transactions, a hand-written mid-burst reset sequence and a set of random
// transactions are played through an AXI slave model; completion status is
// predicted by a transaction-level reference model and data beats by an
// expected queue.
// ---------------------------------------------------------------------------
module tb_axi_burst_master;
    localparam int ID_W = 4;
    localparam int DW   = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic            cmd_valid, cmd_ready, cmd_write;
    logic [31:0]     cmd_addr;
    logic [3:0]      cmd_len;
    logic [ID_W-1:0] cmd_id;
    logic            wr_valid, wr_ready;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_strb;
    logic            rd_valid, rd_ready, rd_last;
    logic [DW-1:0]   rd_data;
    logic            done_valid, done_write, done_err;
    logic [ID_W-1:0] done_id;
    logic [1:0]      done_resp;
    logic [2:0]      dbg_state;

    axi_burst_master_if #(.ID_W(ID_W), .DW(DW)) axi ();

    axi_burst_master #(.AXI_ID_W(ID_W), .AXI_DW(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_id     (cmd_id),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .done_valid (done_valid),
        .done_write (done_write),
        .done_id    (done_id),
        .done_resp  (done_resp),
        .done_err   (done_err),
        .dbg_state  (dbg_state),
        .axi        (axi)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic             write;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [3:0]       id;
        int               addr_delay;  // cycles awready/arready held low
        logic             rand_stall;  // random source/sink/slave stalls
        int               gap_beat;    // source idles 2 cycles before this beat (-1 none)
        logic [1:0]       bresp;
        logic             bad_bid;
        logic [15:0][1:0] rresp;       // rresp per read beat
        int               rlast_beat;  // index of the beat carrying rlast
        logic             bad_rid;     // first read beat carries a wrong rid
        logic [1:0]       exp_resp;
        logic             exp_err;
    } vec_t;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) if (done_valid === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic write, input logic [31:0] addr, input logic [3:0] len,
                                input logic [3:0] id, input int addr_delay, input logic rand_stall,
                                input int gap_beat, input logic [1:0] bresp, input logic bad_bid,
                                input logic [31:0] rresp, input int rlast_beat, input logic bad_rid,
                                input logic [1:0] exp_resp, input logic exp_err);
        vec_t v;
        v.write = write; v.addr = addr; v.len = len; v.id = id;
        v.addr_delay = addr_delay; v.rand_stall = rand_stall; v.gap_beat = gap_beat;
        v.bresp = bresp; v.bad_bid = bad_bid; v.rresp = rresp;
        v.rlast_beat = rlast_beat; v.bad_rid = bad_rid;
        v.exp_resp = exp_resp; v.exp_err = exp_err;
        return v;
    endfunction

    // Transaction-level expectation: a write reports its bresp and flags a
    // wrong bid; a read reports the worst rresp over every beat delivered and
    // flags a wrong rid or an rlast that is not on beat len.
    function automatic void ref_model(input vec_t v, output logic [1:0] resp, output logic err);
        if (v.write) begin
            resp = v.bresp;
            err  = v.bad_bid;
        end else begin
            resp = 2'b00;
            for (int i = 0; i <= v.rlast_beat; i++)
                if (v.rresp[i] > resp) resp = v.rresp[i];
            err = v.bad_rid || (v.rlast_beat != int'(v.len));
        end
    endfunction

    // ---------------- driver: one full transaction ----------------
    task automatic run_vec(input vec_t v);
        logic [31:0] data [16];
        logic [3:0]  strb [16];
        int beat, cyc, gap, d0, nbeats;
        logic hs;
        d0     = done_cnt;
        nbeats = v.write ? int'(v.len) + 1 : v.rlast_beat + 1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            data[i] = $urandom();
            strb[i] = 4'($urandom_range(1, 15));
        end
        for (int i = 0; i < nbeats; i++) exp_q.push_back(data[i]);

        // command
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len; cmd_id = v.id;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;

        // address phase; the local source already offers data to catch early W
        for (int k = 0; k <= v.addr_delay; k++) begin
            if (v.write) axi.awready = (k == v.addr_delay);
            else         axi.arready = (k == v.addr_delay);
            wr_valid = v.write; wr_data = data[0]; wr_strb = strb[0];
            @(negedge clk);
            if (v.write) begin
                check("awvalid", axi.awvalid, 1);
                check("aw_fields", {axi.awaddr, axi.awlen, axi.awid, axi.awsize, axi.awburst},
                      {v.addr, v.len, v.id, 3'b010, 2'b01});
                check("w_before_aw", axi.wvalid, 0);
            end else begin
                check("arvalid", axi.arvalid, 1);
                check("ar_fields", {axi.araddr, axi.arlen, axi.arid, axi.arsize, axi.arburst},
                      {v.addr, v.len, v.id, 3'b010, 2'b01});
            end
            tick();
        end
        axi.awready = 1'b0; axi.arready = 1'b0; wr_valid = 1'b0;

        beat = 0; cyc = 0; gap = 0;
        if (v.write) begin
            while (beat < nbeats && cyc < 400) begin
                if (v.gap_beat == beat && gap < 2) begin
                    wr_valid = 1'b0; gap++;
                end else begin
                    wr_valid = v.rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                wr_data = data[beat]; wr_strb = strb[beat];
                axi.wready = v.rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(negedge clk);
                if (cyc == 0) check("aw_drop", axi.awvalid, 0);
                check("wvalid_follow", axi.wvalid, wr_valid);
                check("wr_ready_follow", wr_ready, axi.wready);
                if (axi.wvalid && axi.wready) begin
                    check("wdata", axi.wdata, exp_q.pop_front());
                    check("wstrb", axi.wstrb, strb[beat]);
                    check("wid", axi.wid, v.id);
                    check("wlast", axi.wlast, beat == nbeats - 1);
                    beat++;
                end
                tick();
                cyc++;
            end
            check("w_beats", beat, nbeats);
            wr_valid = 1'b0; axi.wready = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            axi.bvalid = 1'b1;
            axi.bid    = v.bad_bid ? (v.id ^ 4'h1) : v.id;
            axi.bresp  = v.bresp;
            @(negedge clk);
            check("bready", axi.bready, 1);
            tick();
            axi.bvalid = 1'b0;
        end else begin
            axi.rvalid = 1'b0;
            while (beat < nbeats && cyc < 400) begin
                if (!axi.rvalid) axi.rvalid = v.rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                axi.rdata = data[beat];
                axi.rresp = v.rresp[beat];
                axi.rlast = (beat == nbeats - 1);
                axi.rid   = (v.bad_rid && beat == 0) ? (v.id ^ 4'h8) : v.id;
                rd_ready  = v.rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                @(negedge clk);
                if (cyc == 0) check("ar_drop", axi.arvalid, 0);
                check("rd_valid_follow", rd_valid, axi.rvalid);
                check("rready_follow", axi.rready, rd_ready);
                hs = axi.rvalid && rd_ready;
                if (hs) begin
                    check("rd_data", rd_data, exp_q.pop_front());
                    check("rd_last", rd_last, beat == nbeats - 1);
                    beat++;
                end
                tick();
                cyc++;
                if (hs) axi.rvalid = 1'b0;
            end
            check("r_beats", beat, nbeats);
            axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
        end

        // completion
        @(negedge clk);
        check("done_valid", done_valid, 1);
        check("done_fields", {done_write, done_id, done_resp, done_err},
              {v.write, v.id, v.exp_resp, v.exp_err});
        check("idle_ready", cmd_ready, 1);
        tick();
        @(negedge clk);
        check("done_pulse", done_valid, 0);
        tick();
        check("done_count", done_cnt, d0 + 1);
    endtask

    // ---------------- main sequence ----------------
    vec_t        vecs [9];
    vec_t        v;
    logic [3:0]  rl;
    logic [1:0]  er;
    logic        ee;
    int          r, d0;

    initial begin
        resetn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
        axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rlast = 0; axi.rresp = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshakes", {cmd_ready, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                                 axi.rready, rd_valid, wr_ready, done_valid}, 0);
        check("rst_fields", {axi.awaddr, axi.awlen, axi.awid, axi.arlen, axi.arid}, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_done", {done_write, done_id, done_resp, done_err}, 0);
        check("rst_state", dbg_state, 0);
        resetn = 1'b1;
        tick(); tick();

        //            wr addr      len id  dly stl gap bresp bb rresp          rl  br  exp   err
        vecs[0] = mk(1, 32'h100, 3, 5,  0, 0, -1, 2'b00, 0, 32'h0,         3,  0, 2'b00, 0);
        vecs[1] = mk(1, 32'h200, 3, 6,  3, 0,  2, 2'b00, 0, 32'h0,         3,  0, 2'b00, 0);
        vecs[2] = mk(0, 32'h040, 0, 2,  0, 0, -1, 2'b00, 0, 32'h0,         0,  0, 2'b00, 0);
        vecs[3] = mk(0, 32'h080, 2, 3,  1, 1, -1, 2'b00, 0, 32'h4,         2,  0, 2'b01, 0);
        vecs[4] = mk(0, 32'h300, 3, 7,  0, 0, -1, 2'b00, 0, 32'h0,         1,  0, 2'b00, 1);
        vecs[5] = mk(1, 32'h400, 1, 9,  0, 0, -1, 2'b00, 1, 32'h0,         1,  0, 2'b00, 1);
        vecs[6] = mk(1, 32'h800, 15, 10, 2, 1, -1, 2'b10, 0, 32'h0,        15, 0, 2'b10, 0);
        vecs[7] = mk(0, 32'hFC0, 15, 15, 0, 1, -1, 2'b00, 0, 32'h3000_0000, 15, 1, 2'b11, 1);
        vecs[8] = mk(0, 32'h010, 1, 1,  0, 0, -1, 2'b00, 0, 32'h8,         2,  0, 2'b10, 1);
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // reset during the second W beat of a write
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_len = 4'd3; cmd_id = 4'hC;
        tick();
        cmd_valid = 1'b0; axi.awready = 1'b1;
        @(negedge clk);
        check("rst_seq_awvalid", axi.awvalid, 1);
        tick();
        axi.awready = 1'b0; wr_valid = 1'b1; axi.wready = 1'b1; wr_data = 32'hA5A5_0001; wr_strb = 4'hF;
        @(negedge clk);
        check("rst_seq_beat1", axi.wvalid, 1);
        tick();
        wr_data = 32'hA5A5_0002;
        @(negedge clk);
        check("rst_seq_beat2", axi.wvalid, 1);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid_valids", {axi.wvalid, axi.awvalid, axi.bready, axi.arvalid, axi.rready,
                                 wr_ready, cmd_ready, done_valid}, 0);
        check("rst_mid_state", dbg_state, 0);
        wr_valid = 1'b0; axi.wready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        check("rst_release_ready", cmd_ready, 1);
        check("rst_release_state", dbg_state, 0);
        tick();
        check("rst_no_done", done_cnt, d0);

        // random transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            rl = 4'($urandom_range(0, 15));
            v.write      = 1'($urandom_range(0, 1));
            v.len        = rl;
            v.id         = 4'($urandom_range(0, 15));
            v.addr       = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 1023 - int'(rl))) << 2);
            v.addr_delay = $urandom_range(0, 3);
            v.rand_stall = 1'b1;
            v.gap_beat   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(rl)) : -1;
            v.bresp      = 2'($urandom_range(0, 3));
            v.bad_bid    = ($urandom_range(0, 7) == 0);
            v.bad_rid    = ($urandom_range(0, 7) == 0);
            v.rresp      = $urandom() & $urandom();
            r = $urandom_range(0, 7);
            v.rlast_beat = int'(rl);
            if (r == 0 && rl > 0) v.rlast_beat = int'(rl) - 1;
            else if (r == 1 && rl < 15) v.rlast_beat = int'(rl) + 1;
            ref_model(v, er, ee);
            v.exp_resp = er;
            v.exp_err  = ee;
            run_vec(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
